// File: rtl/soc_system_fpga_pio_edge_irq_pkg.sv
// Shared constants for the parametrised edge-capture input PIO:
// register word offsets and the minimum synchroniser depth.
package soc_system_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_RISE_EN  = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_FALL_EN  = 3'd4;
  localparam logic [2:0] ADDR_DEB_LEN  = 3'd5;

  localparam int MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/soc_system_fpga_pio_edge_irq_if.sv
// Avalon-MM slave bus of the PIO as seen from the lightweight HPS-to-FPGA bridge.
// Handshake: no waitrequest; a write is taken on any clk where chipselect & ~write_n,
// and readdata shows mux(address) one clk after address is presented, chipselect ignored.
interface soc_system_fpga_pio_edge_irq_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, output chipselect, output write_n, output writedata,
                  input readdata);
  modport slave  (input address, input chipselect, input write_n, input writedata,
                  output readdata);
endinterface

// File: rtl/soc_system_fpga_pio_edge_irq_chan_filter.sv
// One input channel: synchroniser chain, tick-based debounce counter and filtered state.
module pio_chan_filter
  import soc_system_pio_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_i,
  input  logic             tick_i,
  input  logic [CNT_W-1:0] deb_len_i,
  output logic             f_o
);

  localparam int N_SYNC = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

  logic [N_SYNC-1:0] sync_q;
  logic              s;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W:0]    cnt_inc;
  logic              f_q, f_d;

  assign s       = sync_q[N_SYNC-1];
  assign cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);

  // DEB_LEN is compared live, so shrinking it mid-count releases on the next tick.
  always_comb begin
    cnt_d = cnt_q;
    f_d   = f_q;
    if (deb_len_i == '0) begin
      f_d   = s;
      cnt_d = '0;
    end else if (s == f_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_inc >= {1'b0, deb_len_i}) begin
        f_d   = s;
        cnt_d = '0;
      end else if (!(&cnt_q)) begin
        cnt_d = cnt_inc[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      f_q    <= 1'b0;
    end else begin
      sync_q <= {sync_q[N_SYNC-2:0], in_i};
      cnt_q  <= cnt_d;
      f_q    <= f_d;
    end
  end

  assign f_o = f_q;

endmodule

// File: rtl/soc_system_fpga_pio_edge_irq.sv
// Parametrised input PIO: per-channel debounce, rise/fall edge capture (W1C) and masked level IRQ.
module soc_system_fpga_pio_edge_irq
  import soc_system_pio_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int PRESCALE    = 50000,
  parameter int CNT_W       = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  soc_system_fpga_pio_edge_irq_if.slave bus,
  input  logic [WIDTH-1:0]              in_port,
  output logic                          irq
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0]  ps_q, ps_d;
  logic             tick;
  logic [WIDTH-1:0] filt, filt_dly_q;
  logic [WIDTH-1:0] rise_en_q, irq_mask_q, edge_cap_q, fall_en_q;
  logic [WIDTH-1:0] edge_cap_d, ev, clr, wr_bits;
  logic [CNT_W-1:0] deb_len_q;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, wr_en;
  logic             unused_wdata;

  assign unused_wdata = ^bus.writedata;

  assign tick = (ps_q == PS_W'(PRESCALE - 1));
  assign ps_d = tick ? '0 : ps_q + PS_W'(1);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    pio_chan_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W)
    ) u_filter (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_i     (in_port[i]),
      .tick_i   (tick),
      .deb_len_i(deb_len_q),
      .f_o      (filt[i])
    );
  end

  assign wr_en   = bus.chipselect & ~bus.write_n;
  assign wr_bits = bus.writedata[WIDTH-1:0];

  // A clear and a new edge on the same bit in one cycle leave the bit set.
  always_comb begin
    ev         = (filt & ~filt_dly_q & rise_en_q) | (~filt & filt_dly_q & fall_en_q);
    clr        = (wr_en && bus.address == ADDR_EDGE_CAP) ? wr_bits : '0;
    edge_cap_d = (edge_cap_q & ~clr) | ev;
  end

  always_comb begin
    readdata_d = '0;
    case (bus.address)
      ADDR_DATA:     readdata_d[WIDTH-1:0] = filt;
      ADDR_RISE_EN:  readdata_d[WIDTH-1:0] = rise_en_q;
      ADDR_IRQ_MASK: readdata_d[WIDTH-1:0] = irq_mask_q;
      ADDR_EDGE_CAP: readdata_d[WIDTH-1:0] = edge_cap_q;
      ADDR_FALL_EN:  readdata_d[WIDTH-1:0] = fall_en_q;
      ADDR_DEB_LEN:  readdata_d[CNT_W-1:0] = deb_len_q;
      default:       readdata_d            = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ps_q       <= '0;
      filt_dly_q <= '0;
      rise_en_q  <= '1;
      irq_mask_q <= '0;
      edge_cap_q <= '0;
      fall_en_q  <= '0;
      deb_len_q  <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      ps_q       <= ps_d;
      filt_dly_q <= filt;
      edge_cap_q <= edge_cap_d;
      readdata_q <= readdata_d;
      irq_q      <= |(edge_cap_q & irq_mask_q);
      if (wr_en) begin
        case (bus.address)
          ADDR_RISE_EN:  rise_en_q  <= wr_bits;
          ADDR_IRQ_MASK: irq_mask_q <= wr_bits;
          ADDR_FALL_EN:  fall_en_q  <= wr_bits;
          ADDR_DEB_LEN:  deb_len_q  <= bus.writedata[CNT_W-1:0];
          default: ;
        endcase
      end
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_soc_system_fpga_pio_edge_irq.sv
// Directed bench for the edge-capture PIO: register map, latency, edge select,
// debounce, clear-vs-edge race, IRQ masking and input held through reset.
module tb_soc_system_fpga_pio_edge_irq;
  import soc_system_pio_pkg::*;

  localparam int WIDTH    = 8;
  localparam int SYNC     = 2;
  localparam int PRESCALE = 4;
  localparam int CNT_W    = 8;

  logic             clk     = 1'b0;
  logic             reset_n = 1'b0;
  logic [WIDTH-1:0] in_port = '0;
  logic             irq;
  logic [31:0]      rd;
  logic [31:0]      exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  soc_system_fpga_pio_edge_irq_if bus_if ();

  soc_system_fpga_pio_edge_irq #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC),
    .PRESCALE   (PRESCALE),
    .CNT_W      (CNT_W)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus_if),
    .in_port(in_port),
    .irq    (irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks: all called right after a negedge, so inputs settle before the posedge
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
    bus_if.address    = addr;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    bus_if.writedata  = data;
    @(negedge clk);
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = '0;
  endtask

  task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
    bus_if.address    = addr;
    bus_if.chipselect = 1'b1;
    @(negedge clk);
    data              = bus_if.readdata;
    bus_if.chipselect = 1'b0;
  endtask

  // scoreboard check
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  initial begin
    bus_if.address    = '0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = '0;

    // reset state
    wait_clks(3);
    check_eq("rst_readdata", bus_if.readdata, 32'h0);
    check_eq("rst_irq", {31'h0, irq}, 32'h0);
    reset_n = 1'b1;
    wait_clks(2);

    exp_q.push_back(32'h0);        // DATA
    exp_q.push_back(32'h0000_00FF); // RISE_EN
    repeat (6) exp_q.push_back(32'h0);
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), rd);
      check_eq($sformatf("rst_off%0d", a), rd, exp_q.pop_front());
    end

    bus_write(3'd6, 32'hFFFF_FFFF);
    bus_read(3'd6, rd);
    check_eq("off6_ignored", rd, 32'h0);

    // DEB_LEN=0 latency on bit0 with mask bit0
    bus_write(ADDR_IRQ_MASK, 32'h1);
    bus_if.address = ADDR_DATA;
    in_port = 8'h01;
    wait_clks(3);
    check_eq("lat_data_e3", bus_if.readdata, 32'h0);
    wait_clks(1);
    check_eq("lat_data_e4", bus_if.readdata, 32'h1);
    check_eq("lat_irq_e4", {31'h0, irq}, 32'h0);
    bus_if.address = ADDR_EDGE_CAP;
    wait_clks(1);
    check_eq("lat_cap_e5", bus_if.readdata, 32'h1);
    check_eq("lat_irq_e5", {31'h0, irq}, 32'h1);

    bus_write(ADDR_EDGE_CAP, 32'h1);
    check_eq("clr_irq_w1", {31'h0, irq}, 32'h1);
    wait_clks(1);
    check_eq("clr_irq_w2", {31'h0, irq}, 32'h0);
    bus_read(ADDR_EDGE_CAP, rd);
    check_eq("clr_cap", rd, 32'h0);

    // falling-only capture on bit7
    bus_write(ADDR_RISE_EN, 32'h0);
    bus_write(ADDR_FALL_EN, 32'h80);
    in_port = 8'h81;
    wait_clks(6);
    bus_read(ADDR_EDGE_CAP, rd);
    check_eq("fall_no_rise", rd, 32'h0);
    in_port = 8'h01;
    wait_clks(6);
    bus_read(ADDR_EDGE_CAP, rd);
    check_eq("fall_cap", rd, 32'h80);
    check_eq("fall_irq_masked", {31'h0, irq}, 32'h0);
    bus_write(ADDR_EDGE_CAP, 32'h80);
    bus_write(ADDR_RISE_EN, 32'hFF);
    bus_write(ADDR_FALL_EN, 32'h0);

    // debounce, PRESCALE=4, DEB_LEN=3
    bus_write(ADDR_DEB_LEN, 32'hFFFF_FF03);
    bus_read(ADDR_DEB_LEN, rd);
    check_eq("deb_len_rb", rd, 32'h3);
    in_port = 8'h05;
    wait_clks(7);
    in_port = 8'h01;
    wait_clks(20);
    bus_read(ADDR_DATA, rd);
    check_eq("glitch_data", rd, 32'h01);
    bus_read(ADDR_EDGE_CAP, rd);
    check_eq("glitch_cap", rd, 32'h0);
    in_port = 8'h05;
    wait_clks(24);
    bus_read(ADDR_DATA, rd);
    check_eq("held_data", rd, 32'h05);
    bus_read(ADDR_EDGE_CAP, rd);
    check_eq("held_cap", rd, 32'h04);

    // clear in the same cycle as a new bit2 rising edge: edge wins
    bus_write(ADDR_DEB_LEN, 32'h0);
    bus_write(ADDR_EDGE_CAP, 32'h04);
    in_port = 8'h01;
    wait_clks(5);
    bus_read(ADDR_EDGE_CAP, rd);
    check_eq("race_pre_cap", rd, 32'h0);
    in_port = 8'h05;
    wait_clks(3);
    bus_write(ADDR_EDGE_CAP, 32'h04);
    bus_read(ADDR_EDGE_CAP, rd);
    check_eq("race_cap", rd, 32'h04);

    // IRQ masking with a pending edge
    bus_write(ADDR_IRQ_MASK, 32'h0);
    wait_clks(2);
    check_eq("mask0_irq", {31'h0, irq}, 32'h0);
    bus_write(ADDR_IRQ_MASK, 32'h04);
    check_eq("mask4_irq_w", {31'h0, irq}, 32'h0);
    wait_clks(1);
    check_eq("mask4_irq_next", {31'h0, irq}, 32'h1);
    bus_write(ADDR_EDGE_CAP, 32'h04);
    wait_clks(2);
    check_eq("mask4_cleared_irq", {31'h0, irq}, 32'h0);
    bus_read(ADDR_EDGE_CAP, rd);
    check_eq("plain_clear_cap", rd, 32'h0);

    // inputs held high through reset give one rising capture each
    reset_n = 1'b0;
    wait_clks(2);
    check_eq("rst2_irq", {31'h0, irq}, 32'h0);
    check_eq("rst2_readdata", bus_if.readdata, 32'h0);
    reset_n = 1'b1;
    wait_clks(6);
    bus_read(ADDR_DATA, rd);
    check_eq("hold_rst_data", rd, 32'h05);
    bus_read(ADDR_EDGE_CAP, rd);
    check_eq("hold_rst_cap", rd, 32'h05);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
